uart_rx_core: RTL and testbench

Parametrised UART receive engine: it replaces the fixed 8-bit, single-sample receiver with a configurable one. It oversamples the serial line on a shared tick and takes a 3-sample majority vote at each bit centre. It supports 5–9 data bits, five parity modes, 1 or 2 stop bits, break detection and a per-word status FIFO. It sits between the pin-side synchroniser domain and the register interface, and everything runs in one clock domain; baud/oversample tick generation is external.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'b000,
        PAR_ODD   = 3'b001,
        PAR_EVEN  = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_e;

    localparam int unsigned ST_PERR = 0;
    localparam int unsigned ST_FERR = 1;
    localparam int unsigned ST_BRK  = 2;
    localparam int unsigned STAT_W  = 3;

    function automatic parity_e decode_parity(input logic [2:0] code);
        case (code)
            3'b001:  return PAR_ODD;
            3'b010:  return PAR_EVEN;
            3'b011:  return PAR_MARK;
            3'b100:  return PAR_SPACE;
            default: return PAR_NONE;
        endcase
    endfunction

    // Unsupported character lengths fall back to the widest one.
    function automatic logic [3:0] clamp_dlen(input logic [3:0] dlen, input int unsigned max_w);
        if (dlen < 4'd5 || 32'(dlen) > max_w) begin
            return 4'(max_w);
        end
        return dlen;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is valid combinationally
// from the read pointer.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so a full FIFO can take both at once.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-of-3 majority per bit, 5..DATA_W data bits, optional
// parity, 1/2 stop bits, break detection and a status-tagged receive FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned OVS         = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd_i,
    input  logic                          os_tick,
    input  logic                          rx_en,
    input  logic [3:0]                    cfg_dlen,
    input  logic [2:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic [DATA_W-1:0]             rdata,
    output logic [2:0]                    rstat,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          busy
);

    localparam int unsigned CW = $clog2(OVS);
    localparam int unsigned WW = DATA_W + STAT_W;

    localparam logic [CW-1:0] CNT_S0  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_S1  = CW'(OVS / 2);
    localparam logic [CW-1:0] CNT_RES = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;

    rx_state_e              state_q;
    rx_state_e              state_d;

    logic [CW-1:0]          cnt_q;
    logic [3:0]             bit_idx_q;
    logic [3:0]             dlen_q;
    parity_e                par_q;
    logic                   stop2_q;
    logic                   stop_idx_q;
    logic                   s0_q;
    logic                   s1_q;
    logic [DATA_W-1:0]      data_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   brk_q;
    logic                   all_zero_q;
    logic                   overrun_q;

    logic                   start_edge;
    logic                   frame_start;
    logic                   in_frame;
    logic                   tick_res;
    logic                   tick_end;
    logic                   maj;
    logic                   last_data;
    logic                   perr_now;
    logic                   final_stop;
    logic                   brk_now;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [STAT_W-1:0]      push_stat;
    logic [WW-1:0]          push_word;
    logic [WW-1:0]          head_word;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rxs         = sync_q[SYNC_STAGES-1];
    assign start_edge  = rxs_prev_q && !rxs;
    assign frame_start = (state_q == StIdle) && rx_en && start_edge;
    assign in_frame    = state_q inside {StStart, StData, StParity, StStop};
    assign tick_res    = os_tick && (cnt_q == CNT_RES);
    assign tick_end    = os_tick && (cnt_q == CNT_END);
    assign maj         = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign last_data   = (bit_idx_q == dlen_q - 4'd1);

    always_comb begin
        perr_now = 1'b0;
        case (par_q)
            PAR_ODD:   perr_now = ~(^data_q ^ maj);
            PAR_EVEN:  perr_now = ^data_q ^ maj;
            PAR_MARK:  perr_now = ~maj;
            PAR_SPACE: perr_now = maj;
            default:   perr_now = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_res && maj) begin
                    state_d = StIdle;
                end else if (tick_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick_end && last_data) begin
                    state_d = (par_q == PAR_NONE) ? StStop : StParity;
                end
            end
            StParity: begin
                if (tick_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (final_stop) begin
                    state_d = brk_now ? StBrkWait : StIdle;
                end
            end
            StBrkWait: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !rx_en) begin
            state_d = StIdle;
        end
    end

    // Outputs and push decode.
    always_comb begin
        busy       = (state_q != StIdle);
        final_stop = 1'b0;
        brk_now    = brk_q;
        if (state_q == StStop && tick_res && rx_en) begin
            final_stop = !stop2_q || stop_idx_q;
        end
        if (state_q == StStop && !stop_idx_q) begin
            brk_now = all_zero_q && !maj;
        end
        push_stat          = '0;
        push_stat[ST_PERR] = perr_q;
        push_stat[ST_FERR] = ferr_q | ~maj | brk_now;
        push_stat[ST_BRK]  = brk_now;
        push               = final_stop;
    end

    assign push_word = {push_stat, data_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            dlen_q     <= 4'(DATA_W);
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            all_zero_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            rxs_prev_q <= rxs;
            if (frame_start) begin
                cnt_q      <= '0;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                data_q     <= '0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                brk_q      <= 1'b0;
                all_zero_q <= 1'b1;
                dlen_q     <= clamp_dlen(cfg_dlen, DATA_W);
                par_q      <= decode_parity(cfg_parity);
                stop2_q    <= cfg_stop2;
            end else if (in_frame && os_tick) begin
                cnt_q <= (cnt_q == CNT_END) ? '0 : cnt_q + CW'(1);
                if (cnt_q == CNT_S0) begin
                    s0_q <= rxs;
                end
                if (cnt_q == CNT_S1) begin
                    s1_q <= rxs;
                end
                if (cnt_q == CNT_RES) begin
                    case (state_q)
                        StData: begin
                            data_q[bit_idx_q] <= maj;
                            if (maj) begin
                                all_zero_q <= 1'b0;
                            end
                        end
                        StParity: begin
                            perr_q <= perr_now;
                            if (maj) begin
                                all_zero_q <= 1'b0;
                            end
                        end
                        StStop: begin
                            ferr_q <= ferr_q | ~maj;
                            if (!stop_idx_q) begin
                                brk_q <= brk_now;
                            end
                        end
                        default: ;
                    endcase
                end
                if (cnt_q == CNT_END) begin
                    if (state_q == StData) begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                    end
                    if (state_q == StStop) begin
                        stop_idx_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign pop  = rvalid && rready;
    assign drop = push && fifo_full && !pop;

    // Set wins over a simultaneous clear so a fresh drop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    assign rvalid  = !fifo_empty;
    assign rdata   = rvalid ? head_word[DATA_W-1:0] : '0;
    assign rstat   = rvalid ? head_word[WW-1:DATA_W] : '0;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: expected words are queued as frames are sent and
// compared by a monitor whenever a word is popped.
module tb_uart_rx_core;

    localparam int unsigned DATA_W      = 9;
    localparam int unsigned OVS         = 16;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned BIT_CLK     = OVS * TICK_DIV;

    logic                         clk        = 1'b0;
    logic                         rst        = 1'b1;
    logic                         rxd_i      = 1'b1;
    logic                         os_tick    = 1'b0;
    logic                         rx_en      = 1'b1;
    logic [3:0]                   cfg_dlen   = 4'd8;
    logic [2:0]                   cfg_parity = 3'b000;
    logic                         cfg_stop2  = 1'b0;
    logic                         rready     = 1'b1;
    logic                         ovr_clr    = 1'b0;
    logic [DATA_W-1:0]            rdata;
    logic [2:0]                   rstat;
    logic                         rvalid;
    logic [$clog2(FIFO_DEPTH):0]  fifo_cnt;
    logic                         overrun;
    logic                         busy;

    int          n_vec = 0;
    int          n_bad = 0;
    int          tick_k = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    logic        ovr_seen;
    logic [8:0]  ovr_vec [5];

    uart_rx_core #(
        .DATA_W      (DATA_W),
        .OVS         (OVS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (rxd_i),
        .os_tick    (os_tick),
        .rx_en      (rx_en),
        .cfg_dlen   (cfg_dlen),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .rdata      (rdata),
        .rstat      (rstat),
        .rvalid     (rvalid),
        .rready     (rready),
        .fifo_cnt   (fifo_cnt),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        os_tick = (tick_k == TICK_DIV - 1);
        tick_k  = (tick_k + 1) % TICK_DIV;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest queued expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", {rstat, rdata});
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_word", 32'({rstat, rdata}), 32'(mon_exp));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd_i = v;
        wait_clk(BIT_CLK);
    endtask

    task automatic start_bit();
        rxd_i = 1'b0;
        wait_clk(SYNC_STAGES);
        check("busy_before_detect", 32'(busy), 32'd0);
        wait_clk(1);
        check("busy_after_detect", 32'(busy), 32'd1);
        wait_clk(BIT_CLK - SYNC_STAGES - 1);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic has_par,
                              input logic par, input logic sp1, input logic has_sp2,
                              input logic sp2);
        start_bit();
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (has_par) send_bit(par);
        send_bit(sp1);
        if (has_sp2) send_bit(sp2);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ovr_vec = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_rstat", 32'(rstat), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 8N1 0xA5, held in the FIFO then popped
        rready = 1'b0;
        exp_q.push_back({3'b000, 9'h0A5});
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("8n1_cnt_after_push", 32'(fifo_cnt), 32'd1);
        check("8n1_rvalid", 32'(rvalid), 32'd1);
        rready = 1'b1;
        wait_clk(3);
        check("8n1_cnt_after_pop", 32'(fifo_cnt), 32'd0);
        check("8n1_rvalid_after_pop", 32'(rvalid), 32'd0);

        // 7E2: wrong parity, then second stop bit low
        cfg_dlen = 4'd7; cfg_parity = 3'b010; cfg_stop2 = 1'b1;
        exp_q.push_back({3'b001, 9'h041});
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({3'b010, 9'h041});
        send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // 9N1 all ones, then a break two characters long
        cfg_dlen = 4'd9; cfg_parity = 3'b000; cfg_stop2 = 1'b0;
        exp_q.push_back({3'b000, 9'h1FF});
        send_frame(9'h1FF, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({3'b110, 9'h000});
        start_bit();
        wait_clk(21 * BIT_CLK);
        check("busy_during_break", 32'(busy), 32'd1);
        rxd_i = 1'b1;
        wait_clk(SYNC_STAGES);
        check("busy_until_line_high", 32'(busy), 32'd1);
        wait_clk(1);
        check("busy_after_break", 32'(busy), 32'd0);
        wait_clk(BIT_CLK);

        // Glitch of 5 ticks is a false start
        cfg_dlen = 4'd8;
        rxd_i = 1'b0;
        wait_clk(5 * TICK_DIV);
        check("glitch_busy", 32'(busy), 32'd1);
        rxd_i = 1'b1;
        wait_clk(BIT_CLK + 8 - 5 * TICK_DIV);
        check("glitch_busy_cleared", 32'(busy), 32'd0);
        wait_clk(BIT_CLK * 10);
        check("glitch_no_push", 32'(fifo_cnt), 32'd0);

        // rx_en dropped mid-DATA
        start_bit();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_clk(BIT_CLK / 2);
        rx_en = 1'b0;
        wait_clk(2);
        check("abort_busy", 32'(busy), 32'd0);
        wait_clk(6 * BIT_CLK);
        rx_en = 1'b1;
        wait_clk(BIT_CLK);
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);

        // Overrun: five frames into a 4-deep FIFO with no pops
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({3'b000, ovr_vec[i]});
            send_frame(ovr_vec[i], 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("ovr_fifo_cnt", 32'(fifo_cnt), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_head_data", 32'(rdata), 32'h011);
        check("ovr_head_stat", 32'(rstat), 32'd0);

        // Sixth drop with ovr_clr held across it: set must win
        ovr_clr  = 1'b1;
        ovr_seen = 1'b0;
        fork
            send_frame(9'h066, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                wait_clk(2);
                check("ovr_clr_clears", 32'(overrun), 32'd0);
                for (int c = 0; c < 14 * BIT_CLK && !ovr_seen; c++) begin
                    wait_clk(1);
                    if (overrun) begin
                        ovr_clr  = 1'b0;
                        ovr_seen = 1'b1;
                    end
                end
                check("ovr_set_beats_clear", 32'(ovr_seen), 32'd1);
            end
        join
        ovr_clr = 1'b0;
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_fifo_cnt_kept", 32'(fifo_cnt), 32'd4);
        rready = 1'b1;
        wait_clk(8);
        check("ovr_drained_cnt", 32'(fifo_cnt), 32'd0);

        // Reset during PARITY with a word already queued
        rready = 1'b0;
        exp_q.push_back({3'b000, 9'h03C});
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_pre_cnt", 32'(fifo_cnt), 32'd1);
        cfg_parity = 3'b001;
        start_bit();
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        rxd_i = 1'b1;
        wait_clk(BIT_CLK / 2);
        check("busy_in_parity", 32'(busy), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        exp_q.delete();
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rstat", 32'(rstat), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_clk(3 * BIT_CLK);
        check("rst_no_late_push", 32'(rvalid), 32'd0);
        check("rst_still_idle", 32'(busy), 32'd0);

        rready = 1'b1;
        wait_clk(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
